// File: rtl/serial_frame_receiver_if.sv
// Serial receive channel: the line into the receiver and the recovered word and status out of it.
// The master drives the serial line. The slave (the receiver) drives the word and the status.
interface serial_frame_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 d;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output d,
    input  data,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  d,
    output data,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel frame receiver: start bit, LSB-first data, optional even parity, stop bit.
// Every line sample is taken mid-bit, measured from the edge that first saw the start bit.
module serial_frame_receiver #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_reset,
  serial_frame_receiver_if.slave if_rx
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  state_e               r_state,        w_state_next;
  logic [CW-1:0]        r_cnt,          w_cnt_next;
  logic [BW-1:0]        r_bit_cnt,      w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift,        w_shift_next;
  logic [DATA_BITS-1:0] r_data,         w_data_next;
  logic                 r_par_err_pend, w_par_err_pend_next;
  logic                 r_valid,        w_valid_next;
  logic                 r_parity_err,   w_parity_err_next;
  logic                 r_frame_err,    w_frame_err_next;
  logic                 w_bit_point;

  // r_cnt reads k-1 at the k-th edge after a sample point, so BIT_LAST marks the next one.
  assign w_bit_point = (r_cnt == BIT_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_data         <= '0;
      r_par_err_pend <= 1'b0;
      r_valid        <= 1'b0;
      r_parity_err   <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_bit_cnt      <= w_bit_cnt_next;
      r_shift        <= w_shift_next;
      r_data         <= w_data_next;
      r_par_err_pend <= w_par_err_pend_next;
      r_valid        <= w_valid_next;
      r_parity_err   <= w_parity_err_next;
      r_frame_err    <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_bit_cnt_next      = r_bit_cnt;
    w_shift_next        = r_shift;
    w_data_next         = r_data;
    w_par_err_pend_next = r_par_err_pend;
    w_valid_next        = 1'b0;
    w_parity_err_next   = r_parity_err;
    w_frame_err_next    = r_frame_err;

    unique case (r_state)
      StIdle: begin
        if (!if_rx.d) begin
          w_state_next = StStart;
          w_cnt_next   = '0;
        end
      end
      StStart: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next     = '0;
          w_bit_cnt_next = '0;
          w_state_next   = if_rx.d ? StIdle : StData;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (w_bit_point) begin
          w_cnt_next     = '0;
          w_shift_next   = DATA_BITS'({if_rx.d, r_shift} >> 1);
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          if (r_bit_cnt == DATA_LAST) begin
            w_state_next = PARITY_EN ? StParity : StStop;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StParity: begin
        if (w_bit_point) begin
          w_cnt_next          = '0;
          w_par_err_pend_next = (^r_shift) ^ if_rx.d;
          w_state_next        = StStop;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StStop: begin
        if (w_bit_point) begin
          w_cnt_next        = '0;
          w_data_next       = r_shift;
          w_parity_err_next = PARITY_EN ? r_par_err_pend : 1'b0;
          w_frame_err_next  = ~if_rx.d;
          w_valid_next      = 1'b1;
          // A low stop bit may be a stuck line; wait for it to go idle first.
          w_state_next      = if_rx.d ? StIdle : StWaitIdle;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StWaitIdle: begin
        if (if_rx.d) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign if_rx.data       = r_data;
  assign if_rx.valid      = r_valid;
  assign if_rx.parity_err = r_parity_err;
  assign if_rx.frame_err  = r_frame_err;
  assign if_rx.busy       = (r_state == StStart) || (r_state == StData) ||
                            (r_state == StParity) || (r_state == StStop);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed and random frames against a frame-level model.
// The model queues the expected word, the flags and the cycle of the valid pulse for every frame.
module tb_serial_frame_receiver;

  localparam int unsigned DB   = 8;
  localparam int unsigned CPB  = 4;
  localparam bit          PEN  = 1'b1;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned LAT  = HALF + (DB + 1 + PEN) * CPB;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
    int unsigned   due;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  exp_t          exp_q[$];
  logic [DB-1:0] exp_data   = '0;
  logic          prev_valid = 1'b0;

  serial_frame_receiver_if #(.DATA_BITS(DB)) rx_if ();

  serial_frame_receiver #(
    .DATA_BITS   (DB),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (PEN)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .if_rx  (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({rx_if.data, rx_if.valid, rx_if.parity_err, rx_if.frame_err, rx_if.busy});
  endfunction

  // Match every valid pulse against the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (rx_if.valid) begin
      check_eq("valid_back_to_back", 32'(prev_valid), 32'd0);
      check_eq("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("valid_cycle", cyc, e.due);
        check_eq("data", 32'(rx_if.data), 32'(e.data));
        check_eq("parity_err", 32'(rx_if.parity_err), 32'(e.perr));
        check_eq("frame_err", 32'(rx_if.frame_err), 32'(e.ferr));
        exp_data = e.data;
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      check_eq("valid_missing", 32'(rx_if.valid), 32'd1);
      void'(exp_q.pop_front());
    end
    prev_valid = rx_if.valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      rx_if.d = 1'b1;
    end
  endtask

  task automatic drive_low(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      rx_if.d = 1'b0;
    end
  endtask

  // The stop bit is held stop_len cycles; HALF+1 ends it right at the stop sample point.
  // abort_j >= 0 asserts reset at that cycle of the frame instead of completing it.
  task automatic send_frame(input logic [DB-1:0] dat, input logic par_bit, input logic stop_bit,
                            input int unsigned stop_len, input int abort_j);
    logic        bits[$];
    exp_t        e;
    int unsigned n;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DB); i++) bits.push_back(dat[i]);
    if (PEN) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    n = (bits.size() - 1) * CPB + stop_len;
    for (int j = 0; j < int'(n); j++) begin
      @(negedge clk);
      if (j == 0) begin
        check_eq("busy_before_start", 32'(rx_if.busy), 32'd0);
        e.data = dat;
        e.perr = PEN ? ((^dat) ^ par_bit) : 1'b0;
        e.ferr = ~stop_bit;
        e.due  = cyc + 1 + LAT;
        exp_q.push_back(e);
      end
      if (j == 1) check_eq("busy_after_start", 32'(rx_if.busy), 32'd1);
      if (j == abort_j) begin
        rst_n = 1'b0;
        #1;
        check_eq("reset_clears_outputs", all_outputs(), 32'd0);
        exp_q.delete();
        exp_data = '0;
        return;
      end
      rx_if.d = bits[j / CPB];
    end
  endtask

  task automatic false_start();
    @(negedge clk);
    check_eq("busy_idle", 32'(rx_if.busy), 32'd0);
    rx_if.d = 1'b0;
    @(negedge clk);
    check_eq("busy_false_start", 32'(rx_if.busy), 32'd1);
    rx_if.d = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("busy_false_start_drop", 32'(rx_if.busy), 32'd0);
    idle(4);
    check_eq("data_after_false_start", 32'(rx_if.data), 32'(exp_data));
  endtask

  initial begin
    logic [DB-1:0] dat;
    logic          pb;
    logic          sb;
    int unsigned   sl;

    rx_if.d = 1'b1;
    rst_n   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_if.d = 1'($urandom % 2);
      check_eq("in_reset", all_outputs(), 32'd0);
    end
    @(negedge clk);
    rx_if.d = 1'b1;
    rst_n   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("busy_after_release", 32'(rx_if.busy), 32'd0);
    end

    // Back-to-back: second start lands on the edge right after the stop sample point.
    send_frame(8'hA5, 1'b0, 1'b1, HALF + 1, -1);
    send_frame(8'h3C, 1'b0, 1'b1, CPB, -1);
    idle(3);

    send_frame(8'h01, 1'b0, 1'b1, CPB, -1);
    idle(2);

    false_start();

    send_frame(8'h5A, 1'b0, 1'b0, CPB, -1);
    drive_low(20);
    check_eq("busy_line_stuck_low", 32'(rx_if.busy), 32'd0);
    idle(1);
    send_frame(8'h0F, 1'b0, 1'b1, CPB, -1);
    idle(2);

    // Reset during data bit 3 (frame bit 4, second cycle).
    send_frame(8'h96, 1'b0, 1'b1, CPB, 4 * int'(CPB) + 1);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(8'hC3, 1'b0, 1'b1, CPB, -1);
    idle(2);

    for (int k = 0; k < 30; k++) begin
      if ($urandom % 5 == 0) false_start();
      dat = DB'($urandom);
      pb  = (^dat) ^ ($urandom % 4 == 0);
      sb  = ($urandom % 6 != 0);
      sl  = (sb && ($urandom % 3 == 0)) ? HALF + 1 : CPB;
      send_frame(dat, pb, sb, sl, -1);
      if (!sb) begin
        drive_low($urandom % 6);
        idle(1 + $urandom % 3);
      end else if (sl == CPB) begin
        idle($urandom % 3);
      end
    end
    idle(6);
    check_eq("pending_frames", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Serial-to-parallel frame receiver: samples a single-bit serial line `d` (idle high), detects a start bit, and shifts in data bits LSB first. It then checks an optional even-parity bit and the stop bit, and presents the received word with a one-cycle `valid` pulse and error flags. It is the reading end of the lab's serial bit-stream path: upstream logic drives `d` one bit per bit-period, and this block recovers the words.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 1..16.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; must be ≥2.
- `PARITY_EN`, 1, 1 = even-parity bit follows the data, 0 = no parity bit.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- `d`  input  1  serial line, synchronous to `clk`, idle level 1.
- `data`  output  DATA_BITS  last received word, registered; holds until the next frame completes.
- `valid`  output  1  one-cycle pulse: a frame completed and `data` and the flags are updated.
- `parity_err`  output  1  parity mismatch on the last frame; always 0 when PARITY_EN=0.
- `frame_err`  output  1  stop bit sampled as 0 on the last frame.
- `busy`  output  1  1 while a frame is in progress (START/DATA/PARITY/STOP).

## Operation
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: when `d`==0 at a rising edge (edge E0), go to START and clear the cycle counter.
  - START: at E0+H, where H = CLKS_PER_BIT/2 (integer floor), re-sample `d`.
    - `d`==0: go to DATA.
    - `d`==1: false start; return to IDLE, no outputs change.
  - DATA: sample bit i (i = 0..DATA_BITS-1) at E0+H+(i+1)·CLKS_PER_BIT.
    - Shift right into a shift register, so bit 0 ends up in `data[0]`.
    - After the last bit, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: sample at the next bit point; error = XOR of received data bits XOR sampled parity bit.
  - STOP: sample at E0+H+(DATA_BITS+1+PARITY_EN)·CLKS_PER_BIT (the stop edge).
    - Load `data` from the shift register; set `parity_err` and `frame_err`; pulse `valid`.
    - `d`==1: go to IDLE.
    - `d`==0: go to WAIT_IDLE.
  - WAIT_IDLE: ignore the line until `d`==1 is seen at an edge, then go to IDLE.
- `valid` pulses on every completed frame, including errored ones; the flags qualify it.
- A false start never asserts `valid` and never modifies `data` or the flags.
- Width rules:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at each sample point.
  - Bit counter is $clog2(DATA_BITS+1) bits.
  - No arithmetic on `data`.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately: no `valid`, `data` cleared. Reception restarts from IDLE after `reset` returns to 1.
- Latency: `valid`=1 during the cycle after the stop edge, i.e. registered at E0+H+(DATA_BITS+1+PARITY_EN)·CLKS_PER_BIT. `data` and the flags change on that same edge.
- `busy`:
  - Rises at E0.
  - Falls at the stop edge.
  - Also falls at E0+H on a false start.
  - Is a decode of the state register; there is no combinational path from `d` to any output.
- Back-to-back frames: if `d`==1 at the stop edge, a start bit may be detected at the very next edge (stop edge + 1).
- `valid` is never high for two consecutive cycles.

## Test plan
All scenarios use the defaults (H=2, frame length 42 cycles after E0).

1. Hold `reset`=0 while toggling `d` → all outputs 0 throughout. Release `reset`=1 with `d`=1 → `busy` stays 0.
2. Send 0xA5 (parity 0, stop 1), then immediately send 0x3C (parity 0) →
   - `valid` pulses once at E0+42 with `data`=0xA5 and both flags 0.
   - A second pulse follows 42 cycles after the second start, with `data`=0x3C.
3. Send 0x01 with parity bit 0 → `valid` pulses, `data`=0x01, `parity_err`=1, `frame_err`=0.
4. Drive `d`=0 for 1 cycle, then 1 → `busy` high from E0 to E0+2, then 0. No `valid`; `data` unchanged.
5. Send 0x5A with stop bit 0, then hold `d`=0 for 20 cycles →
   - `valid` pulses with `frame_err`=1 and `data`=0x5A.
   - No new frame starts until `d`=1 for ≥1 edge; the next valid frame 0x0F is received correctly.
6. Assert `reset`=0 during data bit 3 of a frame → outputs clear within the same cycle and no `valid` pulse. A following 0xC3 frame is received with `data`=0xC3 and both flags 0.
